// File: rtl/adder8_share_arb.sv
// adder8_share_arb: one 8-bit modulo-256 adder shared by NREQ requesters.
// A round-robin arbiter feeds a single result register with a valid/ready
// handshake on the consumer side.
module adder8_share_arb #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned RR_INIT = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [8*NREQ-1:0]    req_a,
   input  logic [8*NREQ-1:0]    req_b,
   output logic [NREQ-1:0]      req_ready,
   output logic                 rsp_valid,
   output logic [7:0]           rsp_sum,
   output logic [2:0]           rsp_id,
   input  logic                 rsp_ready,
   output logic [15:0]          busy_cnt
);

   localparam int unsigned DW  = 8;
   localparam int unsigned IDW = 3;
   localparam int unsigned CW  = 16;

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   rr_ptr_q;
   logic [NREQ-1:0]  rot;
   logic [IDW:0]     cand;
   logic             gnt_any;
   logic [IDW-1:0]   gnt_idx;
   logic [DW-1:0]    op_a, op_b, sum;
   logic             can_accept;
   logic             xfer;

   // Round-robin pick: rotate so rr_ptr sits at bit 0, take the lowest set bit
   always_comb begin
      rot     = NREQ'({req_valid, req_valid} >> rr_ptr_q);
      gnt_any = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (!gnt_any && rot[i]) begin
            gnt_any = 1'b1;
            cand    = {1'b0, rr_ptr_q} + (IDW+1)'(i);
            gnt_idx = (cand >= (IDW+1)'(NREQ)) ? IDW'(cand - (IDW+1)'(NREQ))
                                                : IDW'(cand);
         end
      end
   end

   // Operand select for the granted requester, then the single shared adder
   always_comb begin
      op_a = '0;
      op_b = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (gnt_idx == IDW'(i)) begin
            op_a = req_a[8*i +: 8];
            op_b = req_b[8*i +: 8];
         end
      end
      sum = op_a + op_b;
   end

   // Grant is suppressed while the held result is not being drained, or in reset
   always_comb begin
      can_accept = (state_q == S_EMPTY) | rsp_ready;
      req_ready  = '0;
      if (rst_n && can_accept && gnt_any) begin
         req_ready = NREQ'(1) << gnt_idx;
      end
      xfer = |(req_valid & req_ready);
   end

   // Result-register occupancy: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_EMPTY: if (xfer) state_d = S_FULL;
         S_FULL: begin
            if (xfer)           state_d = S_FULL;
            else if (rsp_ready) state_d = S_EMPTY;
         end
         default: state_d = S_EMPTY;
      endcase
   end

   // Occupancy state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_EMPTY;
      else        state_q <= state_d;
   end

   // Result payload, round-robin pointer and saturating transfer counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_sum  <= '0;
         rsp_id   <= '0;
         rr_ptr_q <= IDW'(RR_INIT);
         busy_cnt <= '0;
      end else if (xfer) begin
         rsp_sum  <= sum;
         rsp_id   <= gnt_idx;
         rr_ptr_q <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
         if (busy_cnt != {CW{1'b1}}) busy_cnt <= busy_cnt + CW'(1);
      end
   end

   assign rsp_valid = (state_q == S_FULL);

endmodule

// File: tb/tb_adder8_share_arb.sv
// Self-checking bench for adder8_share_arb: directed vector table, directed
// corner sequences, and randomized traffic against a behavioural model.
module tb_adder8_share_arb;

   localparam int NREQ = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [8*NREQ-1:0] req_a, req_b;
   logic [NREQ-1:0]   req_ready;
   logic              rsp_valid;
   logic [7:0]        rsp_sum;
   logic [2:0]        rsp_id;
   logic              rsp_ready;
   logic [15:0]       busy_cnt;

   int checks = 0;
   int errors = 0;

   // behavioural model state
   bit m_full;
   int m_sum, m_id, m_ptr, m_cnt;
   logic [NREQ-1:0] last_ready;

   typedef struct {
      logic [3:0]  v;
      logic [31:0] a;
      logic [31:0] b;
      logic        rr;
      logic [3:0]  e_ready;
      logic        e_valid;
      logic [7:0]  e_sum;
      logic [2:0]  e_id;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t tbl[7];

   adder8_share_arb #(.NREQ(NREQ), .RR_INIT(0)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a),
      .req_b(req_b), .req_ready(req_ready), .rsp_valid(rsp_valid),
      .rsp_sum(rsp_sum), .rsp_id(rsp_id), .rsp_ready(rsp_ready),
      .busy_cnt(busy_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // First valid requester at or after ptr, wrapping; -1 when none
   function automatic int model_grant(input logic [NREQ-1:0] v, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         int j;
         j = (ptr + k) % NREQ;
         if (v[j]) return j;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_full = 0; m_sum = 0; m_id = 0; m_ptr = 0; m_cnt = 0;
   endtask

   // One clock cycle of traffic, checked against the model before and after the edge
   task automatic apply(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b,
                        input logic rr);
      int g;
      bit can;
      req_valid = v; req_a = a; req_b = b; rsp_ready = rr;
      #1;
      last_ready = req_ready;
      can = !m_full || rr;
      g = can ? model_grant(v, m_ptr) : -1;
      chk("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
      @(posedge clk);
      if (g >= 0) begin
         m_sum  = (int'(a[8*g +: 8]) + int'(b[8*g +: 8])) % 256;
         m_id   = g;
         m_full = 1;
         m_ptr  = (g + 1) % NREQ;
         if (m_cnt < 65535) m_cnt++;
      end else if (m_full && rr) begin
         m_full = 0;
      end
      #1;
      chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
      chk("rsp_sum", 32'(rsp_sum), 32'(m_sum));
      chk("rsp_id", 32'(rsp_id), 32'(m_id));
      chk("busy_cnt", 32'(busy_cnt), 32'(m_cnt));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = 4'hF; req_a = '1; req_b = '1; rsp_ready = 1'b1;
      #1;
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_sum", 32'(rsp_sum), 0);
      chk("rst_rsp_id", 32'(rsp_id), 0);
      chk("rst_busy_cnt", 32'(busy_cnt), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
      model_reset();

      //            v        a             b             rr  ready    vld  sum    id    cnt
      tbl[0] = '{4'b0001, 32'h00000012, 32'h00000034, 1'b1, 4'b0001, 1'b1, 8'h46, 3'd0, 16'd1};
      tbl[1] = '{4'b0010, 32'h0000FF99, 32'h00000177, 1'b1, 4'b0010, 1'b1, 8'h00, 3'd1, 16'd2};
      tbl[2] = '{4'b0100, 32'h00800000, 32'h00800000, 1'b1, 4'b0100, 1'b1, 8'h00, 3'd2, 16'd3};
      tbl[3] = '{4'b1000, 32'h7F000000, 32'h01000000, 1'b1, 4'b1000, 1'b1, 8'h80, 3'd3, 16'd4};
      tbl[4] = '{4'b0000, 32'h00000000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h80, 3'd3, 16'd4};
      tbl[5] = '{4'b1010, 32'h33000500, 32'h44000600, 1'b1, 4'b0010, 1'b1, 8'h0B, 3'd1, 16'd5};
      tbl[6] = '{4'b1011, 32'h100000EE, 32'h20000011, 1'b1, 4'b1000, 1'b1, 8'h30, 3'd3, 16'd6};

      do_reset();

      // directed vectors: single request, wrap cases, pointer behaviour
      for (int i = 0; i < 7; i++) begin
         apply(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].rr);
         chk($sformatf("tbl%0d_ready", i), 32'(last_ready), 32'(tbl[i].e_ready));
         chk($sformatf("tbl%0d_valid", i), 32'(rsp_valid), 32'(tbl[i].e_valid));
         chk($sformatf("tbl%0d_sum", i), 32'(rsp_sum), 32'(tbl[i].e_sum));
         chk($sformatf("tbl%0d_id", i), 32'(rsp_id), 32'(tbl[i].e_id));
         chk($sformatf("tbl%0d_cnt", i), 32'(busy_cnt), 32'(tbl[i].e_cnt));
      end

      // round robin with all requesters valid and consumer always ready
      do_reset();
      for (int k = 0; k < 5; k++) begin
         apply(4'hF, $urandom, $urandom, 1'b1);
         chk("rr_grant", 32'(last_ready), 32'd1 << (k % 4));
         chk("rr_valid", 32'(rsp_valid), 1);
         chk("rr_id", 32'(rsp_id), 32'(k % 4));
      end

      // backpressure: hold id=2 / sum=A0 while requester 1 waits
      apply(4'b0100, 32'h00500000, 32'h00500000, 1'b1);
      chk("bp_load_sum", 32'(rsp_sum), 32'h A0);
      chk("bp_load_id", 32'(rsp_id), 2);
      for (int k = 0; k < 3; k++) begin
         apply(4'b0010, $urandom, $urandom, 1'b0);
         chk("bp_ready", 32'(last_ready), 0);
         chk("bp_valid", 32'(rsp_valid), 1);
         chk("bp_sum", 32'(rsp_sum), 32'hA0);
         chk("bp_id", 32'(rsp_id), 2);
      end
      apply(4'b0010, 32'h00000100, 32'h00000200, 1'b1);
      chk("bp_release_ready", 32'(last_ready), 32'b0010);
      chk("bp_release_id", 32'(rsp_id), 1);
      chk("bp_release_sum", 32'(rsp_sum), 3);

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         apply(4'($urandom), $urandom, $urandom, ($urandom_range(0, 9) < 7));
      end

      // asynchronous reset mid-operation with rr_ptr at 3
      apply(4'b0100, 32'h00010000, 32'h00020000, 1'b1);
      req_valid = 4'hF; rsp_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_valid", 32'(rsp_valid), 0);
      chk("midrst_cnt", 32'(busy_cnt), 0);
      chk("midrst_ready", 32'(req_ready), 0);
      model_reset();
      #1 rst_n = 1'b1;
      apply(4'hF, 32'h04030201, 32'h01010101, 1'b1);
      chk("midrst_first_grant", 32'(last_ready), 32'b0001);
      chk("midrst_first_sum", 32'(rsp_sum), 2);

      // saturation of the transfer counter
      do_reset();
      req_valid = 4'b0001; req_a = 32'h1; req_b = 32'h1; rsp_ready = 1'b1;
      repeat (65534) @(posedge clk);
      #1 chk("sat_fffe", 32'(busy_cnt), 32'hFFFE);
      @(posedge clk);
      #1 chk("sat_ffff", 32'(busy_cnt), 32'hFFFF);
      repeat (2) @(posedge clk);
      #1 chk("sat_hold", 32'(busy_cnt), 32'hFFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
